// File: rtl/sound_pkg.sv
// Shared types and helpers for the halfwave PWM output stage.
package sound_pkg;

   localparam int SAMPLE_W = 8;
   localparam int VOL_W    = 4;

   typedef enum logic [1:0] {S_OFF, S_POS, S_NEG, S_DEAD} pwm_state_t;
   typedef enum logic [1:0] {POL_OFF, POL_POS, POL_NEG} pol_t;

   // Gain of (vol+1)/16; the 12-bit product cannot overflow for 8-bit mag.
   function automatic logic [SAMPLE_W-1:0] scale_duty(input logic [SAMPLE_W-1:0] mag,
                                                      input logic [VOL_W-1:0]    vol);
      logic [11:0] prod;
      prod = 12'(mag) * (12'(vol) + 12'd1);
      return prod[11:4];
   endfunction

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// Leg-select FSM with break-before-make dead time on direct POS<->NEG reversals.
// State registered; new targets accepted only on load, no backpressure.
module pwm_deadtime_fsm
   import sound_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int DEADTIME = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   input  pol_t       target,
   output pwm_state_t state
);

   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEADTIME - 1);

   pwm_state_t       state_nxt;
   logic [CNT_W-1:0] dead_cnt, dead_nxt;
   pol_t             tgt, tgt_nxt;

   function automatic pwm_state_t pol_state(input pol_t p);
      case (p)
         POL_POS: return S_POS;
         POL_NEG: return S_NEG;
         default: return S_OFF;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_OFF;
         dead_cnt <= '0;
         tgt      <= POL_OFF;
      end else begin
         state    <= state_nxt;
         dead_cnt <= dead_nxt;
         tgt      <= tgt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      dead_nxt  = dead_cnt;
      tgt_nxt   = tgt;
      if (!enable) begin
         state_nxt = S_OFF;
         dead_nxt  = '0;
         tgt_nxt   = POL_OFF;
      end else begin
         case (state)
            S_OFF, S_POS, S_NEG: begin
               if (load) begin
                  if ((state == S_POS && target == POL_NEG) ||
                      (state == S_NEG && target == POL_POS)) begin
                     state_nxt = S_DEAD;
                     dead_nxt  = DEAD_LOAD;
                     tgt_nxt   = target;
                  end else begin
                     state_nxt = pol_state(target);
                  end
               end
            end
            S_DEAD: begin
               // Re-targeting keeps the running dead time unless it flips polarity again.
               if (load)
                  tgt_nxt = target;
               if (load && ((tgt == POL_POS && target == POL_NEG) ||
                            (tgt == POL_NEG && target == POL_POS)))
                  dead_nxt = DEAD_LOAD;
               else if (dead_cnt == '0)
                  state_nxt = pol_state(tgt_nxt);
               else
                  dead_nxt = dead_cnt - CNT_W'(1);
            end
            default: state_nxt = S_OFF;
         endcase
      end
   end

endmodule

// File: rtl/halfwave_pwm_out.sv
// Halfwave magnitude to two-leg PWM: samples latch on period boundaries, scaled by volume.
// Outputs registered one clock after cnt/state; inputs are strobed, no backpressure (overrun flags loss).
module halfwave_pwm_out
   import sound_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int DEADTIME = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] pos_in,
   input  logic [SAMPLE_W-1:0] neg_in,
   input  logic                sample_stb,
   input  logic [VOL_W-1:0]    volume,
   input  logic                enable,
   output logic                pwm_p,
   output logic                pwm_n,
   output logic                period_stb,
   output logic                overrun,
   output logic                fault
);

   localparam int CMP_W = (PWM_BITS > SAMPLE_W) ? PWM_BITS : SAMPLE_W;
   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0] cnt;
   logic [SAMPLE_W-1:0] pend_pos, pend_neg, duty_act, load_mag;
   logic                pending_valid, boundary, load, duty_on;
   pol_t                load_pol;
   pwm_state_t          state;

   assign boundary = (cnt == CNT_MAX);
   assign load     = enable && boundary && pending_valid;
   assign duty_on  = CMP_W'(cnt) < CMP_W'(duty_act);

   always_comb begin
      load_pol = POL_OFF;
      load_mag = '0;
      if (pend_pos != '0 && pend_neg == '0) begin
         load_pol = POL_POS;
         load_mag = pend_pos;
      end else if (pend_neg != '0 && pend_pos == '0) begin
         load_pol = POL_NEG;
         load_mag = pend_neg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt           <= '0;
         pend_pos      <= '0;
         pend_neg      <= '0;
         pending_valid <= 1'b0;
         duty_act      <= '0;
         period_stb    <= 1'b0;
         overrun       <= 1'b0;
         fault         <= 1'b0;
         pwm_p         <= 1'b0;
         pwm_n         <= 1'b0;
      end else begin
         cnt        <= cnt + PWM_BITS'(1);
         period_stb <= boundary;
         overrun    <= 1'b0;
         fault      <= 1'b0;
         if (!enable) begin
            pending_valid <= 1'b0;
         end else begin
            if (load) begin
               duty_act      <= scale_duty(load_mag, volume);
               fault         <= (pend_pos != '0) && (pend_neg != '0);
               pending_valid <= 1'b0;
            end
            // A strobe on the boundary edge queues behind the value being applied.
            if (sample_stb) begin
               pend_pos      <= pos_in;
               pend_neg      <= neg_in;
               pending_valid <= 1'b1;
               overrun       <= pending_valid && !boundary;
            end
         end
         pwm_p <= enable && (state == S_POS) && duty_on;
         pwm_n <= enable && (state == S_NEG) && duty_on;
      end
   end

   pwm_deadtime_fsm #(
      .CNT_W    (PWM_BITS),
      .DEADTIME (DEADTIME)
   ) u_fsm (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .load   (load),
      .target (load_pol),
      .state  (state)
   );

endmodule

// File: tb/tb_halfwave_pwm_out.sv
// Bench for halfwave_pwm_out: vector table, hand-built corner sequences, randomized periods vs a per-period model.
module tb_halfwave_pwm_out;

   localparam int PWM_BITS = 8;
   localparam int DEADTIME = 8;
   localparam int PERIOD   = 256;
   localparam int NVEC     = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pos_in = '0;
   logic [7:0] neg_in = '0;
   logic       sample_stb = 1'b0;
   logic [3:0] volume = '0;
   logic       enable = 1'b0;
   logic       pwm_p, pwm_n, period_stb, overrun, fault;

   always #5 clk = ~clk;

   halfwave_pwm_out #(.PWM_BITS(PWM_BITS), .DEADTIME(DEADTIME)) dut (
      .clk        (clk),
      .reset      (reset),
      .pos_in     (pos_in),
      .neg_in     (neg_in),
      .sample_stb (sample_stb),
      .volume     (volume),
      .enable     (enable),
      .pwm_p      (pwm_p),
      .pwm_n      (pwm_n),
      .period_stb (period_stb),
      .overrun    (overrun),
      .fault      (fault)
   );

   // Free-running period position, restarted by reset like the counter it mirrors.
   int tcnt = 0;
   always @(posedge clk) tcnt <= reset ? 0 : (tcnt + 1) % PERIOD;

   int checks = 0, failures = 0;
   int np = 0, nn = 0, ps = 0, ov = 0, ft = 0, overlap = 0, ps_bad = 0;
   bit ps_armed = 1'b0;

   typedef struct {
      int pos, neg, vol, exp_p, exp_n, exp_fault;
   } vec_t;
   vec_t vecs [NVEC];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      np += int'(pwm_p);
      nn += int'(pwm_n);
      ps += int'(period_stb);
      ov += int'(overrun);
      ft += int'(fault);
      if (pwm_p && pwm_n) overlap++;
      if (ps_armed && (period_stb != (tcnt == 0))) ps_bad++;
   endtask

   task automatic goto_cnt(input int c);
      int guard = 0;
      while (tcnt != c && guard < 2 * PERIOD) begin
         step();
         guard++;
      end
      if (tcnt != c) begin
         checks++;
         failures++;
         $display("FAIL goto_timeout: got %0d expected %0d", tcnt, c);
      end
   endtask

   task automatic strobe(input int p, input int n);
      pos_in     = 8'(p);
      neg_in     = 8'(n);
      sample_stb = 1'b1;
      step();
      sample_stb = 1'b0;
   endtask

   // Called at cnt==0; samples cnt=1..255,0 which reflect the state of cnt=0..255.
   task automatic measure();
      np = 0;
      nn = 0;
      ps = 0;
      repeat (PERIOD) step();
   endtask

   initial begin
      int model_pol, newpol, mag, duty, dead, high;
      int rpos, rneg, rvol, c1, c2, two, kind;

      vecs[0]  = '{128, 0,   15, 128, 0,   0};
      vecs[1]  = '{200, 0,   7,  100, 0,   0};
      vecs[2]  = '{255, 0,   0,  15,  0,   0};
      vecs[3]  = '{64,  0,   15, 64,  0,   0};
      vecs[4]  = '{0,   64,  15, 0,   56,  0};
      vecs[5]  = '{0,   255, 15, 0,   255, 0};
      vecs[6]  = '{0,   0,   15, 0,   0,   0};
      vecs[7]  = '{100, 0,   15, 100, 0,   0};
      vecs[8]  = '{5,   5,   15, 0,   0,   1};
      vecs[9]  = '{0,   200, 3,  0,   50,  0};
      vecs[10] = '{30,  0,   15, 22,  0,   0};
      vecs[11] = '{4,   0,   15, 4,   0,   0};
      vecs[12] = '{0,   6,   15, 0,   0,   0};
      vecs[13] = '{0,   6,   15, 0,   6,   0};
      vecs[14] = '{1,   0,   15, 0,   0,   0};

      repeat (3) step();
      check("rst_pwm_p", int'(pwm_p), 0);
      check("rst_pwm_n", int'(pwm_n), 0);
      check("rst_period_stb", int'(period_stb), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_fault", int'(fault), 0);
      reset  = 1'b0;
      enable = 1'b1;
      volume = 4'd15;

      goto_cnt(10);
      ps_armed = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         goto_cnt(10);
         ov = 0;
         ft = 0;
         volume = 4'(vecs[i].vol);
         strobe(vecs[i].pos, vecs[i].neg);
         goto_cnt(0);
         measure();
         check($sformatf("vec%0d_p_high", i), np, vecs[i].exp_p);
         check($sformatf("vec%0d_n_high", i), nn, vecs[i].exp_n);
         check($sformatf("vec%0d_fault", i), ft, vecs[i].exp_fault);
         check($sformatf("vec%0d_overrun", i), ov, 0);
      end

      // Two strobes in one period: last wins, one overrun pulse.
      goto_cnt(10);
      ov = 0;
      volume = 4'd15;
      strobe(10, 0);
      goto_cnt(20);
      strobe(20, 0);
      goto_cnt(0);
      measure();
      check("ovr_count", ov, 1);
      check("ovr_p_high", np, 20);

      // Strobe on the boundary cycle waits one more period.
      goto_cnt(100);
      ov = 0;
      strobe(30, 0);
      goto_cnt(255);
      strobe(40, 0);
      measure();
      check("bnd_first_p_high", np, 30);
      measure();
      check("bnd_second_p_high", np, 40);
      check("bnd_overrun", ov, 0);

      // Disable mid-period drops outputs and discards the pending sample.
      goto_cnt(10);
      strobe(90, 0);
      goto_cnt(20);
      check("dis_pre_p", int'(pwm_p), 1);
      enable = 1'b0;
      step();
      check("dis_p", int'(pwm_p), 0);
      check("dis_n", int'(pwm_n), 0);
      goto_cnt(30);
      enable = 1'b1;
      goto_cnt(0);
      measure();
      check("reen_idle_p", np, 0);
      check("reen_idle_n", nn, 0);
      goto_cnt(10);
      strobe(0, 50);
      goto_cnt(0);
      measure();
      check("reen_n_high", nn, 50);
      check("reen_p_high", np, 0);

      // Reset mid-period.
      goto_cnt(20);
      check("rst_pre_n", int'(pwm_n), 1);
      ps_armed = 1'b0;
      reset = 1'b1;
      step();
      check("midrst_p", int'(pwm_p), 0);
      check("midrst_n", int'(pwm_n), 0);
      ov = 0;
      ft = 0;
      repeat (2) step();
      check("midrst_ovr_fault", ov + ft, 0);
      reset = 1'b0;
      goto_cnt(10);
      ps_armed = 1'b1;
      goto_cnt(0);
      measure();
      check("postrst_p", np, 0);
      check("postrst_n", nn, 0);
      goto_cnt(10);
      strobe(0, 80);
      goto_cnt(0);
      measure();
      check("postrst_n_high", nn, 80);

      // Randomized periods against a per-period model (0=OFF, 1=POS, 2=NEG).
      model_pol = 2;
      for (int k = 0; k < 20; k++) begin
         kind = $urandom_range(0, 9);
         rpos = 0;
         rneg = 0;
         if (kind < 4) rpos = $urandom_range(1, 255);
         else if (kind < 8) rneg = $urandom_range(1, 255);
         else if (kind == 9) begin
            rpos = $urandom_range(1, 255);
            rneg = $urandom_range(1, 255);
         end
         rvol = $urandom_range(0, 15);
         two  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         c1   = $urandom_range(0, 200);
         c2   = $urandom_range(c1 + 1, 254);
         ov = 0;
         ft = 0;
         volume = 4'(rvol);
         goto_cnt(c1);
         if (two != 0) begin
            strobe($urandom_range(0, 255), $urandom_range(0, 255));
            goto_cnt(c2);
         end
         strobe(rpos, rneg);
         goto_cnt(0);
         volume = 4'($urandom_range(0, 15));
         measure();

         newpol = 0;
         mag    = 0;
         if (rpos != 0 && rneg == 0) begin newpol = 1; mag = rpos; end
         else if (rneg != 0 && rpos == 0) begin newpol = 2; mag = rneg; end
         duty = (mag * (rvol + 1)) / 16;
         dead = ((model_pol == 1 && newpol == 2) || (model_pol == 2 && newpol == 1)) ? DEADTIME : 0;
         high = (duty > dead) ? duty - dead : 0;
         check($sformatf("rnd%0d_p_high", k), np, (newpol == 1) ? high : 0);
         check($sformatf("rnd%0d_n_high", k), nn, (newpol == 2) ? high : 0);
         check($sformatf("rnd%0d_fault", k), ft, (rpos != 0 && rneg != 0) ? 1 : 0);
         check($sformatf("rnd%0d_overrun", k), ov, two);
         model_pol = newpol;
      end

      check("legs_overlap_cycles", overlap, 0);
      check("period_stb_misaligned", ps_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/halfwave_pwm_out.md
Name: halfwave_pwm_out

Overview:
Output stage directly downstream of the sine LUT generator. Takes its split positive/negative halfwave magnitudes (8-bit each) and drives a two-leg H-bridge/speaker pair with fixed-period PWM. Adds sample latching on period boundaries, 4-bit volume scaling and break-before-make dead time on polarity reversal. `period_stb` is intended to drive the generator's step strobe.

Parameters:
- PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS clocks.
- DEADTIME, 8, clocks both legs held low after a direct POS<->NEG reversal. Legal range 1..2^PWM_BITS-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pos_in  in  8  positive halfwave magnitude
- neg_in  in  8  negative halfwave magnitude
- sample_stb  in  1  one-clock strobe; capture pos_in/neg_in
- volume  in  4  gain; effective gain (volume+1)/16
- enable  in  1  output enable
- pwm_p  out  1  positive leg drive, registered
- pwm_n  out  1  negative leg drive, registered
- period_stb  out  1  one-clock pulse during the cycle where cnt==0
- overrun  out  1  one-clock pulse when a second sample_stb arrives in one period
- fault  out  1  one-clock pulse when the sample applied at a boundary has both inputs nonzero

Behaviour:
- Reset values:
  - cnt=0, pending regs=0, pending_valid=0, duty_act=0, state=S_OFF, dead_cnt=0.
  - All outputs 0.
- Counter: cnt increments every clk, free-running, wraps 2^PWM_BITS-1 -> 0.
  - enable does not stop cnt.
  - "Boundary" means the cycle where cnt==2^PWM_BITS-1.
- period_stb is registered and is high exactly during cycles with cnt==0.
- Capture:
  - When sample_stb=1: pend_pos<=pos_in, pend_neg<=neg_in, pending_valid<=1.
  - A second strobe while pending_valid=1 and no boundary in between: pending is overwritten (last wins) and overrun pulses the next cycle.
- Boundary load:
  - If pending_valid=1, the pending value held before the edge is applied and pending_valid<=0.
  - If sample_stb and boundary coincide: the old pending value is applied; the new sample becomes pending for the next boundary.
  - No pending sample: duty_act and polarity are held.
- Scaling: mag = pos or neg input. duty = (mag * (volume+1)) >> 4, using a 12-bit intermediate truncated to 8 bits. volume is sampled at the boundary only.
- Polarity decode of the applied sample:
  - pos!=0, neg==0 -> POS.
  - neg!=0, pos==0 -> NEG.
  - both 0 -> OFF.
  - both !=0 -> OFF, and fault pulses the next cycle.
- FSM states: S_OFF, S_POS, S_NEG, S_DEAD (S_DEAD holds the target polarity).
  - Transitions evaluated at the boundary.
  - S_POS with target NEG, or S_NEG with target POS -> S_DEAD, dead_cnt<=DEADTIME-1.
  - Any other target: go directly to it (OFF->POS/NEG needs no dead time).
  - S_DEAD: dead_cnt decrements each clk; at 0 -> target state. Dead time eats the start of the new period.
  - A boundary occurring while in S_DEAD: re-target only. dead_cnt is not reloaded unless the new target is the opposite polarity, in which case it is reloaded.
- Outputs, registered (1-clock latency from cnt/state):
  - pwm_p <= enable && state==S_POS && cnt<duty_act.
  - pwm_n <= enable && state==S_NEG && cnt<duty_act.
  - duty 0 -> never high. duty 255 with PWM_BITS=8 -> high 255 of 256 clocks.
- enable low:
  - Both outputs low on the next cycle.
  - FSM forced to S_OFF immediately; pending is discarded.
  - Re-enable resumes at the next boundary with the next captured sample.
- Invariant: pwm_p && pwm_n is never 1 in any cycle, including reset and enable edges.
- Reset mid-operation: all state returns to reset values on the next edge; outputs are low the cycle after reset is sampled.

Decomposition:
- Shared package `sound_pkg`:
  - FSM state enum.
  - Polarity enum {POL_OFF, POL_POS, POL_NEG}.
  - SAMPLE_W=8, VOL_W=4 constants.
  - Function `scale_duty(mag, vol)`.
- One natural sub-module: `pwm_deadtime_fsm` (state, dead_cnt, target). Counter, capture and comparator stay in the top.

Test Plan:
- Reset, then enable=1, volume=15, strobe pos=128, neg=0 -> after the first boundary, pwm_p high exactly 128 of 256 clocks per period; pwm_n stays 0; period_stb pulses every 256 clocks.
- volume=7, pos=200 -> duty=100, giving 100 high clocks per period. volume=0, pos=255 -> duty=15.
- Steady POS duty 64, then strobe neg=64 -> at the boundary both legs are low for 8 clocks. pwm_n is then high for clocks cnt=8..63 (56 clocks). No overlap cycle.
- Two strobes in one period (pos=10, then pos=20) -> overrun pulses once; duty 20 is applied at the boundary. Strobe coinciding with the boundary is applied one period later.
- Strobe pos=5, neg=5 -> fault pulses once; both legs low for the period.
- Mid-period enable=0 or reset=1 -> both outputs low the next cycle. After release: OFF until the next sample is applied at a boundary; no dead time from OFF.
